// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and phase constants plus the strobe bundle shared by the controller and ALU
package cpu_pkg;
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;
    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
        logic halt;
    } ctrl_t;
    function automatic logic is_aluop(input logic [2:0] op);
        return op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_LDA;
    endfunction
endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational phase/opcode/zero/halted -> datapath strobes (phase_i, opcode_i, a_is_zero_i, halted_i in; ctrl_o out)
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0] phase_i,
    input  logic [2:0] opcode_i,
    input  logic       a_is_zero_i,
    input  logic       halted_i,
    output ctrl_t      ctrl_o
);
    logic alu;
    logic late;
    always_comb begin
        alu            = is_aluop(opcode_i);
        late           = phase_i == PH_ALU_OP || phase_i == PH_STORE;
        ctrl_o         = '0;
        ctrl_o.halt    = halted_i || (phase_i == PH_OP_ADDR && opcode_i == OP_HLT);
        ctrl_o.sel     = !halted_i && phase_i <= PH_IDLE;
        ctrl_o.rd      = !halted_i && ((phase_i >= PH_INST_FETCH && phase_i <= PH_IDLE) || (phase_i >= PH_OP_FETCH && alu));
        ctrl_o.ld_ir   = !halted_i && (phase_i == PH_INST_LOAD || phase_i == PH_IDLE);
        ctrl_o.inc_pc  = !halted_i && (phase_i == PH_OP_ADDR || (phase_i == PH_ALU_OP && opcode_i == OP_SKZ && a_is_zero_i));
        ctrl_o.ld_pc   = !halted_i && late && opcode_i == OP_JMP;
        ctrl_o.ld_ac   = !halted_i && phase_i == PH_STORE && alu;
        ctrl_o.wr      = !halted_i && phase_i == PH_STORE && opcode_i == OP_STO;
        ctrl_o.data_e  = !halted_i && late && opcode_i == OP_STO;
    end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase fetch/execute sequencer with sticky halt and retired-instruction counter (clk, rst, enable, opcode, a_is_zero in; strobes, halt, phase, retired out)
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [2:0]           opcode,
    input  logic                 a_is_zero,
    output logic                 sel,
    output logic                 rd,
    output logic                 ld_ir,
    output logic                 inc_pc,
    output logic                 ld_pc,
    output logic                 ld_ac,
    output logic                 wr,
    output logic                 data_e,
    output logic                 halt,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] retired
);
    logic [2:0]           phase_q, phase_d;
    logic                 halted_q, halted_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 adv, stop;
    ctrl_t                ctrl;
    always_comb begin
        adv       = enable && !halted_q;
        stop      = adv && phase_q == PH_OP_ADDR && opcode == OP_HLT;
        phase_d   = (adv && !stop) ? phase_q + 3'd1 : phase_q;
        halted_d  = halted_q || stop;
        retired_d = (adv && phase_q == PH_STORE) ? retired_q + CNT_WIDTH'(1) : retired_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_INST_ADDR;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            phase_q   <= phase_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end
    cpu_ctrl_decode u_decode (
        .phase_i     (phase_q),
        .opcode_i    (opcode),
        .a_is_zero_i (a_is_zero),
        .halted_i    (halted_q),
        .ctrl_o      (ctrl)
    );
    assign {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt} = ctrl;
    assign phase   = phase_q;
    assign retired = retired_q;
endmodule
